// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles every non-clock/reset signal of the instruction fetch unit:
//   the controller strobes, the instruction-memory req/ack bus and the
//   status/field outputs returned to the controller and datapath.
//
//   Parameters : ADDR_W  PC / instruction-memory address width
//                DATA_W  instruction word width
//
//   Modports   : slave  - the fetch unit's view (strobes and memory
//                         response in; request, fields, status out)
//                master - the surrounding system's view (controller,
//                         memory and datapath side)
//
//   Signals    : loadIR, loadPC, incPC, selA   controller strobes
//                im_req, im_addr               memory read request/address
//                im_ack, im_rdata              memory response (1-cycle ack)
//                opcode, operand               decoded IR fields
//                pc                            current program counter
//                ir_valid, busy                fetch status
//                fetch_err, overrun            error indications
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);

  // controller strobes
  logic              loadIR;
  logic              loadPC;
  logic              incPC;
  logic              selA;

  // instruction-memory bus
  logic              im_req;
  logic [ADDR_W-1:0] im_addr;
  logic              im_ack;
  logic [DATA_W-1:0] im_rdata;

  // fields and status
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc;
  logic              ir_valid;
  logic              busy;
  logic              fetch_err;
  logic              overrun;

  modport slave (
    input  loadIR, loadPC, incPC, selA,
    input  im_ack, im_rdata,
    output im_req, im_addr,
    output opcode, operand, pc,
    output ir_valid, busy, fetch_err, overrun
  );

  modport master (
    output loadIR, loadPC, incPC, selA,
    output im_ack, im_rdata,
    input  im_req, im_addr,
    input  opcode, operand, pc,
    input  ir_valid, busy, fetch_err, overrun
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Owns the program counter and the instruction register. On a loadIR
//   strobe from the controller it reads the word at the current PC from
//   instruction memory over a req/ack handshake and latches it into IR.
//   The opcode goes back to the controller, the operand to the datapath,
//   and the operand also serves as the jump target for PC loads.
//
//   Parameters : ADDR_W    PC / memory address width (default 12)
//                DATA_W    instruction width (default 16); DATA_W >= ADDR_W+4
//                RESET_PC  PC value after reset (default 0)
//                TIMEOUT   cycles to wait for im_ack before aborting,
//                          legal range 1..65535 (default 255)
//
//   Ports      : clk    rising-edge system clock
//                rst_n  asynchronous active-low reset
//                bus    instr_fetch_unit_if.slave
//                         in : loadIR, loadPC, incPC, selA, im_ack, im_rdata
//                         out: im_req, im_addr, opcode, operand, pc,
//                              ir_valid, busy, fetch_err, overrun
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int                ADDR_W   = 12,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_fetch_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last counter value before abort: the request stays up for exactly
  // TIMEOUT cycles when no ack arrives.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t            stateReg;
  logic [ADDR_W-1:0] pcReg;
  logic [ADDR_W-1:0] imAddrReg;
  logic [DATA_W-1:0] irReg;
  logic              imReqReg;
  logic              irValidReg;
  logic              busyReg;
  logic              fetchErrReg;
  logic              overrunReg;
  logic [15:0]       waitCntReg;

  logic [ADDR_W-1:0] operandField;
  logic [3:0]        opcodeField;

  // Fields are taken straight from the registered IR, so the jump target
  // never sees a word that is only arriving on im_rdata this cycle.
  assign operandField = irReg[ADDR_W-1:0];
  assign opcodeField  = irReg[DATA_W-1 -: 4];

  // -------------------------------------------------------------------------
  // Fetch FSM: IDLE -> REQ -> DONE -> IDLE, with a timeout abort REQ -> IDLE.
  // All handshake and status outputs are registered here.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      imAddrReg   <= '0;
      irReg       <= '0;
      imReqReg    <= 1'b0;
      irValidReg  <= 1'b0;
      busyReg     <= 1'b0;
      fetchErrReg <= 1'b0;
      overrunReg  <= 1'b0;
      waitCntReg  <= '0;
    end else begin
      // overrun is a single-cycle pulse unless re-armed below
      overrunReg <= 1'b0;

      case (stateReg)
        // DONE behaves like IDLE so a fetch can start on the very next
        // strobe; ir_valid is kept until a new fetch begins.
        IDLE, DONE: begin
          if (bus.loadIR) begin
            imAddrReg  <= pcReg;
            imReqReg   <= 1'b1;
            busyReg    <= 1'b1;
            irValidReg <= 1'b0;
            waitCntReg <= '0;
            stateReg   <= REQ;
          end else begin
            stateReg   <= IDLE;
          end
        end

        REQ: begin
          // A second fetch request cannot be queued; flag it and drop it.
          if (bus.loadIR) begin
            overrunReg <= 1'b1;
          end

          if (bus.im_ack) begin
            irReg      <= bus.im_rdata;
            imReqReg   <= 1'b0;
            busyReg    <= 1'b0;
            irValidReg <= 1'b1;
            stateReg   <= DONE;
          end else if (waitCntReg == TIMEOUT_LAST) begin
            // Abort: IR keeps its old contents, ir_valid stays low and the
            // error flag is sticky until reset.
            imReqReg    <= 1'b0;
            busyReg     <= 1'b0;
            fetchErrReg <= 1'b1;
            stateReg    <= IDLE;
          end else begin
            waitCntReg <= waitCntReg + 16'd1;
          end
        end

        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Program counter. Updated every edge independent of the fetch state; the
  // in-flight fetch address is held separately in imAddrReg.
  //   loadPC & selA  : jump to IR operand (wins over incPC)
  //   loadPC & !selA : hold (load-state strobe, no PC effect)
  //   incPC          : increment, wrapping modulo 2^ADDR_W
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg <= RESET_PC;
    end else if (bus.loadPC) begin
      if (bus.selA) begin
        pcReg <= operandField;
      end
    end else if (bus.incPC) begin
      pcReg <= pcReg + ADDR_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Output drive
  // -------------------------------------------------------------------------
  assign bus.im_req    = imReqReg;
  assign bus.im_addr   = imAddrReg;
  assign bus.opcode    = opcodeField;
  assign bus.operand   = operandField;
  assign bus.pc        = pcReg;
  assign bus.ir_valid  = irValidReg;
  assign bus.busy      = busyReg;
  assign bus.fetch_err = fetchErrReg;
  assign bus.overrun   = overrunReg;

endmodule
